// File: rtl/alu_result_checker.sv
// MISR-based response compactor for the ALU: skips pipeline latency, folds F/C2 into
// a 16-bit signature for NUM_VECTORS results, then flags pass against GOLDEN.
module alu_result_checker #(
    parameter int unsigned NUM_VECTORS = 32'h0040_0000,
    parameter int unsigned LATENCY     = 1,
    parameter logic [15:0] POLY        = 16'h1021,
    parameter logic [15:0] SEED        = 16'hFFFF,
    parameter logic [15:0] GOLDEN      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        G,
    input  logic [7:0]  F,
    input  logic        C2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [22:0] vec_count
);

    localparam int SKW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [22:0]    NV  = 23'(NUM_VECTORS);
    localparam logic [SKW-1:0] LAT = SKW'(LATENCY);

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [SKW-1:0] skip_cnt;
    logic [SKW-1:0] skip_inc;
    logic [22:0]    cnt_inc;
    logic [15:0]    sig_nxt;
    logic           launch;

    assign launch   = start && (state == IDLE || state == DONE);
    assign skip_inc = skip_cnt + SKW'(1);
    assign cnt_inc  = vec_count + 23'd1;
    assign sig_nxt  = ({signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0000))
                      ^ {7'b0, C2, F};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (LATENCY > 0) ? SKIP : RUN;
            SKIP:       if (G && skip_inc == LAT) state_nxt = RUN;
            RUN:        if (G && cnt_inc == NV) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SKIP) || (state == RUN);
        done = (state == DONE);
    end

    // Datapath: everything holds when G=0; only a launch from IDLE/DONE bypasses the gate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature <= 16'h0000;
            vec_count <= 23'd0;
            skip_cnt  <= '0;
            pass      <= 1'b0;
        end else if (launch) begin
            signature <= SEED;
            vec_count <= 23'd0;
            skip_cnt  <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                SKIP: if (G) skip_cnt <= skip_inc;
                RUN: if (G) begin
                    signature <= sig_nxt;
                    vec_count <= cnt_inc;
                    if (cnt_inc == NV) pass <= (sig_nxt == GOLDEN);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed LATENCY=0 checks plus a per-cycle
// scoreboard for a LATENCY=1, 4-vector configuration (gating, abort, ignored start).
module tb_alu_result_checker;

    localparam int LAT = 1;
    localparam int NV  = 4;

    logic clk = 1'b0;
    logic rst, start, G, C2;
    logic [7:0] F;

    logic a_busy, a_done, a_pass, b_busy, b_done, b_pass, c_busy, c_done, c_pass;
    logic [15:0] a_sig, b_sig, c_sig;
    logic [22:0] a_cnt, b_cnt, c_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.NUM_VECTORS(1), .LATENCY(0), .GOLDEN(16'hEFDE)) u_a (
        .clk(clk), .rst(rst), .start(start), .G(G), .F(F), .C2(C2),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_count(a_cnt));
    alu_result_checker #(.NUM_VECTORS(1), .LATENCY(0), .GOLDEN(16'hEFDF)) u_b (
        .clk(clk), .rst(rst), .start(start), .G(G), .F(F), .C2(C2),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_count(b_cnt));
    alu_result_checker #(.NUM_VECTORS(NV), .LATENCY(LAT), .GOLDEN(16'h0000)) u_c (
        .clk(clk), .rst(rst), .start(start), .G(G), .F(F), .C2(C2),
        .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig), .vec_count(c_cnt));

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sig;
        logic [22:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model for u_c: counts gated-in edges since launch.
    bit          m_run, m_done, m_pass;
    int          m_act;
    logic [15:0] m_sig;
    logic [15:0] ref_final;
    logic [7:0]  vf[NV];
    logic        vc[NV];

    function automatic logic [15:0] misr(input logic [15:0] s, input logic c2, input logic [7:0] f);
        logic [15:0] fb;
        fb = s[15] ? 16'h1021 : 16'h0000;
        return (({s[14:0], 1'b0}) ^ fb) ^ {7'b0, c2, f};
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_act = 0; m_sig = 16'h0000;
    endtask

    // One clock: drive inputs, push model expectation, clock, pop and compare u_c.
    task automatic cyc(input logic g, input logic [7:0] f, input logic c2, input logic st);
        exp_t e, got;
        G = g; F = f; C2 = c2; start = st;
        if (st && !m_run) begin
            m_run = 1; m_done = 0; m_pass = 0; m_act = 0; m_sig = 16'hFFFF;
        end else if (m_run && g) begin
            m_act++;
            if (m_act > LAT) m_sig = misr(m_sig, c2, f);
            if (m_act == LAT + NV) begin
                m_run = 0; m_done = 1; m_pass = (m_sig == 16'h0000);
            end
        end
        e.busy = m_run;
        e.done = m_done;
        e.pass = m_pass;
        e.sig  = m_sig;
        e.cnt  = (m_act > LAT) ? 23'(m_act - LAT) : 23'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        e = exp_q.pop_front();
        got = '{c_busy, c_done, c_pass, c_sig, c_cnt};
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL sb_cycle t=%0t: got busy=%b done=%b pass=%b sig=%h cnt=%0d, want busy=%b done=%b pass=%b sig=%h cnt=%0d",
                     $time, got.busy, got.done, got.pass, got.sig, got.cnt,
                     e.busy, e.done, e.pass, e.sig, e.cnt);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; start = 1'b0; G = 1'b1; F = 8'h00; C2 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({a_busy, a_done, a_pass, a_sig, a_cnt} !== 41'd0) begin
            fails++; $display("FAIL reset_a: got %h want 0", {a_busy, a_done, a_pass, a_sig, a_cnt});
        end
        tests++;
        if ({c_busy, c_done, c_pass, c_sig, c_cnt} !== 41'd0) begin
            fails++; $display("FAIL reset_c: got %h want 0", {c_busy, c_done, c_pass, c_sig, c_cnt});
        end
    endtask

    task automatic test_lat0();
        apply_reset();
        F = 8'h00; C2 = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        tests++;
        if (a_busy !== 1'b1 || a_cnt !== 23'd0 || a_sig !== 16'hFFFF) begin
            fails++; $display("FAIL lat0_launch: got busy=%b cnt=%0d sig=%h want 1 0 ffff", a_busy, a_cnt, a_sig);
        end
        @(posedge clk); #1;
        tests++;
        if (a_sig !== 16'hEFDF || a_cnt !== 23'd1 || a_done !== 1'b1 || a_busy !== 1'b0) begin
            fails++; $display("FAIL lat0_f00: got sig=%h cnt=%0d done=%b busy=%b want efdf 1 1 0", a_sig, a_cnt, a_done, a_busy);
        end
        tests++;
        if (a_pass !== 1'b0 || b_pass !== 1'b1) begin
            fails++; $display("FAIL lat0_pass_f00: got a=%b b=%b want a=0 b=1", a_pass, b_pass);
        end
        // Relaunch from DONE with G low: start must still be honoured.
        G = 1'b0; F = 8'h01; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        tests++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || a_pass !== 1'b0 || a_sig !== 16'hFFFF || a_cnt !== 23'd0) begin
            fails++; $display("FAIL lat0_relaunch: got busy=%b done=%b pass=%b sig=%h cnt=%0d want 1 0 0 ffff 0",
                              a_busy, a_done, a_pass, a_sig, a_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (a_sig !== 16'hFFFF || a_busy !== 1'b1) begin
            fails++; $display("FAIL lat0_gated: got sig=%h busy=%b want ffff 1", a_sig, a_busy);
        end
        G = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (a_sig !== 16'hEFDE || b_sig !== 16'hEFDE || a_done !== 1'b1) begin
            fails++; $display("FAIL lat0_f01: got a=%h b=%h done=%b want efde efde 1", a_sig, b_sig, a_done);
        end
        tests++;
        if (a_pass !== 1'b1 || b_pass !== 1'b0) begin
            fails++; $display("FAIL lat0_pass_f01: got a=%b b=%b want a=1 b=0", a_pass, b_pass);
        end
    endtask

    task automatic test_run4();
        apply_reset();
        for (int i = 0; i < NV; i++) begin
            vf[i] = 8'($urandom); vc[i] = 1'($urandom);
        end
        cyc(1'b1, 8'($urandom), 1'($urandom), 1'b1);
        cyc(1'b1, 8'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < NV; i++) cyc(1'b1, vf[i], vc[i], i == 1);
        ref_final = m_sig;
        cyc(1'b0, 8'($urandom), 1'($urandom), 1'b0);
        tests++;
        if (c_done !== 1'b1 || c_sig !== ref_final) begin
            fails++; $display("FAIL run4_final: got done=%b sig=%h want 1 %h", c_done, c_sig, ref_final);
        end
    endtask

    task automatic test_gating();
        apply_reset();
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'hA5, 1'b1, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1'b1, vf[0], vc[0], 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'($urandom), 1'($urandom), 1'b0);
        for (int i = 1; i < NV; i++) cyc(1'b1, vf[i], vc[i], 1'b0);
        tests++;
        if (c_done !== 1'b1 || c_sig !== ref_final) begin
            fails++; $display("FAIL gating_final: got done=%b sig=%h want 1 %h", c_done, c_sig, ref_final);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({c_busy, c_done, c_pass, c_sig, c_cnt} !== 41'd0) begin
            fails++; $display("FAIL abort_reset: got %h want 0", {c_busy, c_done, c_pass, c_sig, c_cnt});
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < NV; i++) cyc(1'b1, vf[i], vc[i], 1'b0);
        tests++;
        if (c_done !== 1'b1 || c_sig !== ref_final) begin
            fails++; $display("FAIL abort_final: got done=%b sig=%h want 1 %h", c_done, c_sig, ref_final);
        end
    endtask

    task automatic test_back_to_back();
        // Relaunch straight from DONE with new data; the scoreboard tracks the second run.
        for (int i = 0; i < NV; i++) begin
            vf[i] = 8'($urandom); vc[i] = 1'($urandom);
        end
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < NV; i++) cyc(1'b1, vf[i], vc[i], 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; G = 1'b0; F = 8'h00; C2 = 1'b0;
        #1;
        test_reset();
        test_lat0();
        test_run4();
        test_gating();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Self-checking response compactor for the ALU. It sits on the ALU output side (F, C2) while an exhaustive stimulus sweep advances the ALU inputs one vector per clock. The block skips the ALU pipeline latency and folds every F/C2 result into a 16-bit MISR signature. After a programmed number of vectors it compares the signature against a golden value and reports pass/fail. It turns the ALU sweep into a synthesizable on-board self-test.

## Interface
Parameters:
- NUM_VECTORS, 22'h3FFFFF+1 (2^22): results to compact; matches the {O,S,C1,A,B} 22-bit sweep; must be ≥1
- LATENCY, 1: clocks between a stimulus vector being applied and its F/C2 being valid
- POLY, 16'h1021: MISR feedback polynomial (x^16+x^12+x^5+1)
- SEED, 16'hFFFF: signature value loaded on start
- GOLDEN, 16'h0000: expected final signature

Ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a run (ignored while busy)
- G  in  1  gate; when 0 the run freezes (no skip count, no compaction, no vector count)
- F  in  8  ALU result
- C2  in  1  ALU carry out
- busy  out  1  high in SKIP or RUN
- done  out  1  high in DONE state
- pass  out  1  valid when done: signature == GOLDEN
- signature  out  16  current MISR contents
- vec_count  out  23  results compacted so far in this run

## Operation
- Reset (rst=0, asynchronous): state=IDLE, signature=16'h0000, vec_count=0, skip counter=0, busy=0, done=0, pass=0.
- FSM states: IDLE, SKIP, RUN, DONE.
- IDLE: on start=1, load signature=SEED, vec_count=0, skip counter=0. Go to SKIP if LATENCY>0, otherwise go to RUN.
- SKIP: each cycle with G=1, increment the skip counter. When it reaches LATENCY, go to RUN on that edge. No compaction happens in SKIP.
- RUN: each cycle with G=1, compact once and increment vec_count. The compaction is: signature ← ({signature[14:0],1'b0} ^ (signature[15] ? POLY : 0)) ^ {7'b0, C2, F}. When the increment makes vec_count equal NUM_VECTORS, go to DONE on the same edge.
- DONE: done=1. pass is registered on entry as (final signature == GOLDEN) and holds. signature and vec_count hold.
  - start=1 in DONE reloads SEED, clears vec_count, clears pass and done, and enters SKIP/RUN exactly as from IDLE.
- start while in SKIP or RUN is ignored.
- G=0 in any state: all registers hold. In IDLE and DONE, start is still honoured regardless of G.
- Width rules: vec_count is 23 bits so 2^22 is representable without wrap. The skip counter is wide enough for LATENCY.

## Timing
- start sampled at edge N → busy=1 after edge N.
- First compaction at edge N+LATENCY+1, using F/C2 present during that cycle.
- With G held at 1, done rises after edge N+LATENCY+NUM_VECTORS, and busy falls on the same edge.
- pass is valid in the same cycle done first reads 1.
- A rst assertion mid-run aborts immediately to the reset values above. There is no resume; a new start is required.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset, then start with LATENCY=0, NUM_VECTORS=1, F=8'h00, C2=0 → one cycle later signature=16'hEFDF, vec_count=1, done=1.
- Same setup with F=8'h01 → signature=16'hEFDE. With GOLDEN=16'hEFDE → pass=1. With GOLDEN=16'hEFDF → pass=0.
- LATENCY=1, NUM_VECTORS=4, start at edge N → busy high after N, done high after edge N+5. vec_count steps 0,0,1,2,3,4. The signature equals the software MISR model over the 4 sampled F/C2 values.
- Hold G=0 for 3 cycles mid-RUN → signature and vec_count frozen for exactly 3 cycles. Final done is delayed by 3 cycles, and the final signature is unchanged vs the ungated run.
- Pulse rst=0 mid-RUN (asynchronously, between edges) → all outputs reset immediately. A later start restarts from SEED, and the final signature matches a clean run.
- Full run with the ALU and the 22-bit incrementing stimulus, GOLDEN from the reference model → done after 2^22+LATENCY cycles with pass=1. Corrupt F bit 0 in one vector → pass=0.
